// File: rtl/pwm_gate_driver_pkg.sv
// Shared types and default timing for the half-bridge gate driver.
// State encoding is fixed because it is exported on state_o for debug.
package pwm_gate_driver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DT_FALL = 3'd1,
      ST_LS_ON   = 3'd2,
      ST_DT_RISE = 3'd3,
      ST_HS_ON   = 3'd4,
      ST_FAULT   = 3'd5
   } pwm_state_e;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_DT      = 10;
   localparam int DEF_MIN_OFF = 50;
   localparam int DEF_MAX_ON  = 2000;

endpackage

// File: rtl/pwm_gate_driver_timer.sv
// Clear/enable saturating counter with an equality compare.
// Shared by dead-time, minimum off-time and max on-time measurement.
module pwm_gate_driver_timer
   import pwm_gate_driver_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] cmp,
   output logic [CNT_W-1:0] cnt,
   output logic             eq
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign eq = (cnt == cmp);

endmodule

// File: rtl/pwm_gate_driver.sv
// SR-style PWM leg controller: dead time, min off-time, max on-time
// watchdog and latched fault shutdown for one half-bridge.
module pwm_gate_driver
   import pwm_gate_driver_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int DT_CYCLES = DEF_DT,
   parameter int MIN_OFF   = DEF_MIN_OFF,
   parameter int MAX_ON    = DEF_MAX_ON
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       set,
   input  logic       reset_pwm,
   input  logic       fault,
   output logic       hs_gate,
   output logic       ls_gate,
   output logic       maxon_trip,
   output logic       fault_lat,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_ON - 1);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_OFF);

   pwm_state_e       state_q;
   pwm_state_e       state_d;
   logic             pend_q;
   logic             trip_d;
   logic             chg;
   logic             min_ok;
   logic             cnt_eq;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cmp;

   assign chg    = (state_d != state_q);
   assign min_ok = (cnt >= MIN_CNT);
   assign cmp    = (state_q == ST_HS_ON) ? MAX_LAST : DT_LAST;

   pwm_gate_driver_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (chg),
      .inc   (1'b1),
      .cmp   (cmp),
      .cnt   (cnt),
      .eq    (cnt_eq)
   );

   always_comb begin
      state_d = state_q;
      trip_d  = 1'b0;
      if (fault) begin
         state_d = ST_FAULT;
      end else if (state_q == ST_FAULT) begin
         if (!en) state_d = ST_IDLE;
      end else if (!en) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_DT_FALL;
            end
            ST_DT_FALL: begin
               if (cnt_eq) state_d = ST_LS_ON;
            end
            ST_LS_ON: begin
               if (min_ok && (set || pend_q)) state_d = ST_DT_RISE;
            end
            ST_DT_RISE: begin
               if (reset_pwm)   state_d = ST_DT_FALL;
               else if (cnt_eq) state_d = ST_HS_ON;
            end
            ST_HS_ON: begin
               if (reset_pwm) begin
                  state_d = ST_DT_FALL;
               end else if (cnt_eq) begin
                  state_d = ST_DT_FALL;
                  trip_d  = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode the next state so they change on the entry edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pend_q     <= 1'b0;
         hs_gate    <= 1'b0;
         ls_gate    <= 1'b0;
         maxon_trip <= 1'b0;
         fault_lat  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hs_gate    <= (state_d == ST_HS_ON);
         ls_gate    <= (state_d == ST_LS_ON);
         maxon_trip <= trip_d;
         fault_lat  <= (state_d == ST_FAULT);
         if (state_d != ST_LS_ON) begin
            pend_q <= 1'b0;
         end else if ((state_q == ST_LS_ON) && set && !min_ok) begin
            pend_q <= 1'b1;
         end
      end
   end

   assign state_o = state_q;

endmodule
